// File: rtl/fetch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_redirect_ctrl
//
// Purpose:
//   Sequences the dual-slot fetch PC register for the A/B issue pair. Arbitrates
//   resolved redirects from execute pipes A (older slot) and B (younger slot)
//   and the slot A/B dispatch stalls. Drives hold / single-advance / redirect
//   controls to the next-PC datapath and the fetch/decode flushes.
//
//   After reset the block issues a boot redirect to RESET_PC. In normal running
//   a redirect is latched and presented on the next cycle. It is held until the
//   next-PC block accepts it, and decode is then flushed for FLUSH_CYCLES cycles.
//
// Parameters:
//   RESET_PC      boot PC presented on the first redirect after reset
//   FLUSH_CYCLES  decode-flush cycles after a redirect is accepted (0..15)
//   CNT_W         statistics counter width (REDIR_STATS_EN builds only)
//
// Optional feature (macro REDIR_STATS_EN):
//   Adds saturating statistics counters stat_redir_cnt / stat_stall_cnt.
//
// Ports:
//   clk               clock
//   rst_n             synchronous active-low reset
//   redir_valid_a     pipe A resolved redirect
//   redir_target_a    pipe A target PC
//   redir_valid_b     pipe B resolved redirect
//   redir_target_b    pipe B target PC
//   stall_a           slot A cannot dispatch
//   stall_b           slot B cannot dispatch
//   fetch_ready       next-PC block accepts a redirect this cycle
//   pc_hold           freeze pcF1/pcF2
//   pc_single         advance one slot (pcF1 <= pcF2)
//   redir_out_valid   redirect request to the next-PC block
//   redir_out_target  redirect PC, bits[1:0] always zero
//   flush_fetch       kill the fetched pair
//   flush_decode      kill decode stage contents
//   busy              controller is not in normal running
//   stat_redir_cnt    RUN->REDIRECT transitions (REDIR_STATS_EN only)
//   stat_stall_cnt    RUN cycles with hold or single-advance (REDIR_STATS_EN only)
// -----------------------------------------------------------------------------
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0001_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redir_valid_a,
  input  logic [31:0] redir_target_a,
  input  logic        redir_valid_b,
  input  logic [31:0] redir_target_b,
  input  logic        stall_a,
  input  logic        stall_b,
  input  logic        fetch_ready,
  output logic        pc_hold,
  output logic        pc_single,
  output logic        redir_out_valid,
  output logic [31:0] redir_out_target,
  output logic        flush_fetch,
  output logic        flush_decode,
  output logic        busy
`ifdef REDIR_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_redir_cnt,
  output logic [CNT_W-1:0] stat_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  // Loaded on accept; FLUSH exits when it reaches zero, so the flush lasts
  // exactly FLUSH_CYCLES cycles. The zero-cycle case bypasses FLUSH entirely.
  localparam logic [3:0] CNT_INIT = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [31:0] tgt_q;
  logic [3:0]  cnt;

  logic        redir_any;
  logic [31:0] redir_sel_target;

  assign redir_any = redir_valid_a | redir_valid_b;

  // Pipe A is the older slot, so its redirect wins; a simultaneous B redirect
  // lies on the wrong path and is dropped. Word alignment is forced here.
  assign redir_sel_target = redir_valid_a ? {redir_target_a[31:2], 2'b00}
                                          : {redir_target_b[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
      tgt_q <= RESET_PC;
      cnt   <= 4'd0;
    end else begin
      case (state)
        BOOT: begin
          if (fetch_ready) state <= RUN;
        end
        RUN: begin
          if (redir_any) begin
            tgt_q <= redir_sel_target;
            state <= REDIRECT;
          end
        end
        REDIRECT: begin
          // New redirects here come from wrong-path instructions being flushed.
          if (fetch_ready) begin
            cnt <= CNT_INIT;
            if (FLUSH_CYCLES == 0) state <= RUN;
            else                   state <= FLUSH;
          end
        end
        FLUSH: begin
          if (cnt == 4'd0) state <= RUN;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= BOOT;
      endcase
    end
  end

  // Stall controls are combinational so slot A/B back-pressure takes effect
  // in the same cycle; a redirect in the same cycle overrides them.
  always_comb begin
    pc_hold          = 1'b0;
    pc_single        = 1'b0;
    redir_out_valid  = 1'b0;
    redir_out_target = tgt_q;
    flush_fetch      = 1'b0;
    flush_decode     = 1'b0;
    busy             = 1'b1;
    case (state)
      BOOT: begin
        redir_out_valid  = 1'b1;
        redir_out_target = RESET_PC;
        pc_hold          = 1'b1;
      end
      RUN: begin
        busy = 1'b0;
        if (!redir_any) begin
          pc_hold   = stall_a;
          pc_single = stall_b & ~stall_a;
        end
      end
      REDIRECT: begin
        redir_out_valid = 1'b1;
        flush_fetch     = 1'b1;
        flush_decode    = 1'b1;
        pc_hold         = 1'b1;
      end
      FLUSH: begin
        flush_decode = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

`ifdef REDIR_STATS_EN
  logic [CNT_W-1:0] cnt_one;
  assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_redir_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (state == RUN && redir_any && !(&stat_redir_cnt))
        stat_redir_cnt <= stat_redir_cnt + cnt_one;
      if (state == RUN && (pc_hold | pc_single) && !(&stat_stall_cnt))
        stat_stall_cnt <= stat_stall_cnt + cnt_one;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

  // Low target bits are discarded by the alignment above.
  logic unused_target_bits;
  assign unused_target_bits = ^{redir_target_a[1:0], redir_target_b[1:0]};

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Testbench for fetch_redirect_ctrl (default parameters, FLUSH_CYCLES = 2).
// A directed vector table covers boot, arbitration, stalls, a long-held
// redirect, alignment and reset during FLUSH. A randomized phase then
// compares the DUT every cycle against a behavioural model.
module tb_fetch_redirect_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0001_0000;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redir_valid_a, redir_valid_b;
  logic [31:0] redir_target_a, redir_target_b;
  logic        stall_a, stall_b, fetch_ready;
  logic        pc_hold, pc_single, redir_out_valid, flush_fetch, flush_decode, busy;
  logic [31:0] redir_out_target;
`ifdef REDIR_STATS_EN
  logic [CNT_W-1:0] stat_redir_cnt, stat_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(
    .RESET_PC(RESET_PC),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .redir_valid_a(redir_valid_a),
    .redir_target_a(redir_target_a),
    .redir_valid_b(redir_valid_b),
    .redir_target_b(redir_target_b),
    .stall_a(stall_a),
    .stall_b(stall_b),
    .fetch_ready(fetch_ready),
    .pc_hold(pc_hold),
    .pc_single(pc_single),
    .redir_out_valid(redir_out_valid),
    .redir_out_target(redir_out_target),
    .flush_fetch(flush_fetch),
    .flush_decode(flush_decode),
    .busy(busy)
`ifdef REDIR_STATS_EN
    ,
    .stat_redir_cnt(stat_redir_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  typedef struct {
    logic        rst_n, ra;
    logic [31:0] ta;
    logic        rb;
    logic [31:0] tb;
    logic        sa, sb, fr;
    logic        hold, single, valid;
    logic [31:0] tgt;
    logic        ff, fd, busy;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: boot pending, redirect awaiting acceptance,
  // remaining flush cycles, and the last accepted target.
  bit          m_boot;
  bit          m_pending;
  int          m_flush_left;
  logic [31:0] m_tgt;
  int          m_redirs;
  int          m_stalls;

  function automatic vec_t mkv(logic r, logic ra, logic [31:0] ta, logic rb, logic [31:0] tb,
                               logic sa, logic sb, logic fr, logic h, logic s, logic v,
                               logic [31:0] t, logic ff, logic fd, logic b);
    vec_t x;
    x.rst_n = r; x.ra = ra; x.ta = ta; x.rb = rb; x.tb = tb;
    x.sa = sa; x.sb = sb; x.fr = fr;
    x.hold = h; x.single = s; x.valid = v; x.tgt = t;
    x.ff = ff; x.fd = fd; x.busy = b;
    return x;
  endfunction

  function automatic logic [37:0] packExp(vec_t v);
    return {v.hold, v.single, v.valid, v.tgt, v.ff, v.fd, v.busy};
  endfunction

  function automatic logic [37:0] modelExpect();
    logic [37:0] e;
    if (m_boot)
      e = {1'b1, 1'b0, 1'b1, RESET_PC, 1'b0, 1'b0, 1'b1};
    else if (m_pending)
      e = {1'b1, 1'b0, 1'b1, m_tgt, 1'b1, 1'b1, 1'b1};
    else if (m_flush_left > 0)
      e = {1'b0, 1'b0, 1'b0, m_tgt, 1'b0, 1'b1, 1'b1};
    else if (redir_valid_a || redir_valid_b)
      e = {1'b0, 1'b0, 1'b0, m_tgt, 1'b0, 1'b0, 1'b0};
    else
      e = {stall_a, stall_b && !stall_a, 1'b0, m_tgt, 1'b0, 1'b0, 1'b0};
    return e;
  endfunction

  task automatic modelUpdate();
    int sat;
    sat = (1 << CNT_W) - 1;
    if (!rst_n) begin
      m_boot = 1; m_pending = 0; m_flush_left = 0; m_tgt = RESET_PC;
      m_redirs = 0; m_stalls = 0;
    end else if (m_boot) begin
      if (fetch_ready) m_boot = 0;
    end else if (m_pending) begin
      if (fetch_ready) begin
        m_pending = 0;
        m_flush_left = FLUSH_CYCLES;
      end
    end else if (m_flush_left > 0) begin
      m_flush_left = m_flush_left - 1;
    end else if (redir_valid_a || redir_valid_b) begin
      m_tgt = (redir_valid_a ? redir_target_a : redir_target_b) & 32'hFFFF_FFFC;
      m_pending = 1;
      if (m_redirs < sat) m_redirs++;
    end else if (stall_a || stall_b) begin
      if (m_stalls < sat) m_stalls++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n = v.rst_n;
    redir_valid_a = v.ra; redir_target_a = v.ta;
    redir_valid_b = v.rb; redir_target_b = v.tb;
    stall_a = v.sa; stall_b = v.sb; fetch_ready = v.fr;
  endtask

  task automatic checkOutput(input string name, input logic [37:0] exp);
    logic [37:0] act;
    act = {pc_hold, pc_single, redir_out_valid, redir_out_target, flush_fetch, flush_decode, busy};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got {hold,single,valid,target,ff,fd,busy}=%b %b %b %h %b %b %b expected %b %b %b %h %b %b %b",
               name, $time, act[37], act[36], act[35], act[34:3], act[2], act[1], act[0],
               exp[37], exp[36], exp[35], exp[34:3], exp[2], exp[1], exp[0]);
    end
  endtask

`ifdef REDIR_STATS_EN
  task automatic checkStats(input string name);
    checks++;
    if (stat_redir_cnt !== CNT_W'(m_redirs) || stat_stall_cnt !== CNT_W'(m_stalls)) begin
      errors++;
      $display("[TB] FAIL %s got redir_cnt=%0d stall_cnt=%0d expected %0d %0d",
               name, stat_redir_cnt, stat_stall_cnt, m_redirs, m_stalls);
    end
  endtask
`endif

  // One clock: model sees inputs held across the edge, then re-align to negedge.
  task automatic advance();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    m_boot = 1; m_pending = 0; m_flush_left = 0; m_tgt = RESET_PC;
    m_redirs = 0; m_stalls = 0;

    //        rst ra ta            rb tb            sa sb fr | h  s  v  tgt           ff fd b
    tbl.push_back(mkv(1, 1, 32'h0000_9000, 0, 32'h0,         1, 0, 0,  1, 0, 1, 32'h0001_0000, 0, 0, 1));
    tbl.push_back(mkv(1, 0, 32'h0,         1, 32'h0000_8000, 0, 1, 0,  1, 0, 1, 32'h0001_0000, 0, 0, 1));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         0, 0, 1,  1, 0, 1, 32'h0001_0000, 0, 0, 1));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         0, 0, 0,  0, 0, 0, 32'h0001_0000, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         1, 1, 0,  1, 0, 0, 32'h0001_0000, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         0, 1, 1,  0, 1, 0, 32'h0001_0000, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         1, 0, 0,  1, 0, 0, 32'h0001_0000, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 32'h0000_2000, 1, 32'h0000_3000, 1, 0, 0,  0, 0, 0, 32'h0001_0000, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mkv(1, 0, 32'h0,       1, 32'h0000_4004, 0, 0, 0,  1, 0, 1, 32'h0000_2000, 1, 1, 1));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         0, 0, 1,  1, 0, 1, 32'h0000_2000, 1, 1, 1));
    tbl.push_back(mkv(1, 1, 32'h0000_6000, 1, 32'h0000_6100, 1, 1, 0,  0, 0, 0, 32'h0000_2000, 0, 1, 1));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         0, 0, 0,  0, 0, 0, 32'h0000_2000, 0, 1, 1));
    tbl.push_back(mkv(1, 1, 32'h0000_5007, 0, 32'h0,         0, 0, 0,  0, 0, 0, 32'h0000_2000, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         0, 0, 1,  1, 0, 1, 32'h0000_5004, 1, 1, 1));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         0, 0, 0,  0, 0, 0, 32'h0000_5004, 0, 1, 1));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         0, 0, 0,  0, 0, 0, 32'h0000_5004, 0, 1, 1));
    tbl.push_back(mkv(1, 0, 32'h0,         1, 32'h0000_7FFE, 0, 0, 0,  0, 0, 0, 32'h0000_5004, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         0, 0, 0,  1, 0, 1, 32'h0000_7FFC, 1, 1, 1));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         0, 0, 1,  1, 0, 1, 32'h0000_7FFC, 1, 1, 1));
    tbl.push_back(mkv(0, 0, 32'h0,         0, 32'h0,         0, 0, 0,  0, 0, 0, 32'h0000_7FFC, 0, 1, 1));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         0, 0, 0,  1, 0, 1, 32'h0001_0000, 0, 0, 1));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         0, 0, 1,  1, 0, 1, 32'h0001_0000, 0, 0, 1));
    tbl.push_back(mkv(1, 0, 32'h0,         0, 32'h0,         0, 0, 0,  0, 0, 0, 32'h0001_0000, 0, 0, 0));

    // Reset sequence, then check the boot state while reset is still held.
    v = mkv(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    applyStimulus(v);
    advance();
    advance();
    #1;
    checkOutput("reset_state", {1'b1, 1'b0, 1'b1, RESET_PC, 1'b0, 1'b0, 1'b1});
`ifdef REDIR_STATS_EN
    checkStats("reset_stats");
`endif

    // Directed vectors, one per clock.
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      #1;
      checkOutput($sformatf("vec%0d", i), packExp(tbl[i]));
      advance();
    end
`ifdef REDIR_STATS_EN
    checkStats("table_stats");
`endif

    // Randomized phase against the model.
    for (int i = 0; i < 600; i++) begin
      v.rst_n = ($urandom_range(0, 63) != 0);
      v.ra = ($urandom_range(0, 4) == 0);
      v.ta = $urandom;
      v.rb = ($urandom_range(0, 3) == 0);
      v.tb = $urandom;
      v.sa = ($urandom_range(0, 2) == 0);
      v.sb = ($urandom_range(0, 2) == 0);
      v.fr = ($urandom_range(0, 1) == 0);
      applyStimulus(v);
      #1;
      checkOutput($sformatf("rand%0d", i), modelExpect());
`ifdef REDIR_STATS_EN
      checkStats($sformatf("rand_stats%0d", i));
`endif
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
